shift_reg_univ: RTL

- Parametrised multi-lane, multi-stage universal shift register; the general-purpose successor to the team's 1-bit serial shift register.
- Modes: hold, shift-up, shift-down and parallel load, selected per cycle.
- Outputs: a runtime-selectable tap, a full parallel view of all stages, and a saturating fill counter tracking how many stages hold written data.
- Used for delay lines, SIPO/PISO conversion and alignment buffers.

---
 rtl/shift_reg_univ_pkg.sv | 17 +
 rtl/shift_reg_univ_if.sv | 33 +++
 rtl/shift_reg_univ_sat_counter.sv | 37 +++
 rtl/shift_reg_univ.sv | 73 +++++++
 4 files changed

// File: rtl/shift_reg_univ_pkg.sv
// Shared mode encodings and parameter helpers for the universal shift register.
package shift_reg_univ_pkg;

    localparam logic [1:0] MODE_HOLD       = 2'b00;
    localparam logic [1:0] MODE_SHIFT_UP   = 2'b01;
    localparam logic [1:0] MODE_SHIFT_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD       = 2'b11;

    // Ceiling log2, usable in parameter defaults; clog2(1) is 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/shift_reg_univ_if.sv
// Control, data and status bundle for shift_reg_univ; the register side uses the slave modport.
interface shift_reg_univ_if
    import shift_reg_univ_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int TAP_W = clog2(DEPTH),
    parameter int CNT_W = clog2(DEPTH + 1)
);

    logic                     i_clr;
    logic [1:0]               i_mode;
    logic [WIDTH-1:0]         i_din;
    logic [WIDTH*DEPTH-1:0]   i_pdata;
    logic [TAP_W-1:0]         i_tap_sel;
    logic [WIDTH-1:0]         o_dout;
    logic [WIDTH-1:0]         o_dout_lo;
    logic [WIDTH-1:0]         o_tap;
    logic [WIDTH*DEPTH-1:0]   o_pdata;
    logic [CNT_W-1:0]         o_fill;
    logic                     o_full;

    modport master (
        output i_clr, i_mode, i_din, i_pdata, i_tap_sel,
        input  o_dout, o_dout_lo, o_tap, o_pdata, o_fill, o_full
    );

    modport slave (
        input  i_clr, i_mode, i_din, i_pdata, i_tap_sel,
        output o_dout, o_dout_lo, o_tap, o_pdata, o_fill, o_full
    );

endinterface

// File: rtl/shift_reg_univ_sat_counter.sv
// Saturating up-counter with a jump-to-max input and a registered at-max flag.
module sat_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    input  logic             i_set,
    output logic [WIDTH-1:0] o_count,
    output logic             o_max
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] count_nxt;

    always_comb begin
        count_nxt = o_count;
        if (i_set)
            count_nxt = MAX_V;
        else if (i_inc && (o_count != MAX_V))
            count_nxt = o_count + WIDTH'(1);
    end

    // The flag follows the next count so it rises on the same edge the count reaches MAX.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_count <= '0;
            o_max   <= 1'b0;
        end else begin
            o_count <= count_nxt;
            o_max   <= (count_nxt == MAX_V);
        end
    end

endmodule

// File: rtl/shift_reg_univ.sv
// Multi-lane universal shift register: hold, shift up/down, parallel load, tap mux and fill count.
module shift_reg_univ
    import shift_reg_univ_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int TAP_W = clog2(DEPTH),
    parameter int CNT_W = clog2(DEPTH + 1)
) (
    input logic            i_clk,
    input logic            i_rst,
    shift_reg_univ_if.slave bus
);

    logic [WIDTH-1:0] stage [DEPTH];
    logic [TAP_W-1:0] tap_sel;
    logic             clear;
    logic             shift;
    logic             load;

    assign clear   = i_rst | bus.i_clr;
    assign shift   = (bus.i_mode == MODE_SHIFT_UP) || (bus.i_mode == MODE_SHIFT_DOWN);
    assign load    = (bus.i_mode == MODE_LOAD);
    assign tap_sel = bus.i_tap_sel;

    always_ff @(posedge i_clk) begin
        if (clear) begin
            for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
        end else begin
            case (bus.i_mode)
                MODE_SHIFT_UP: begin
                    for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
                    stage[0] <= bus.i_din;
                end
                MODE_SHIFT_DOWN: begin
                    for (int k = 0; k < DEPTH - 1; k++) stage[k] <= stage[k+1];
                    stage[DEPTH-1] <= bus.i_din;
                end
                MODE_LOAD: begin
                    for (int k = 0; k < DEPTH; k++) stage[k] <= bus.i_pdata[k*WIDTH +: WIDTH];
                end
                default: ;
            endcase
        end
    end

    sat_counter #(
        .WIDTH (CNT_W),
        .MAX   (DEPTH)
    ) u_fill (
        .i_clk   (i_clk),
        .i_rst   (clear),
        .i_inc   (shift),
        .i_set   (load),
        .o_count (bus.o_fill),
        .o_max   (bus.o_full)
    );

    assign bus.o_dout    = stage[DEPTH-1];
    assign bus.o_dout_lo = stage[0];

    always_comb begin
        bus.o_pdata = '0;
        for (int k = 0; k < DEPTH; k++) bus.o_pdata[k*WIDTH +: WIDTH] = stage[k];
    end

    // Out-of-range selects (possible when DEPTH is not a power of two) read as zero.
    always_comb begin
        bus.o_tap = '0;
        if (int'(tap_sel) < DEPTH) bus.o_tap = stage[tap_sel];
    end

endmodule
